pc_write_unit: RTL and testbench

- Parametrised successor to the single-OR PC write-enable combiner in the multicycle MIPS datapath.
- Owns the PC register. Evaluates four branch condition types from ALU flags, and arbitrates jump, taken-branch and sequential PC writes.
- Latches redirects that arrive during a stall and replays them on the first non-stall cycle.
- Keeps saturating taken / not-taken branch counters for performance debug.

---
 rtl/pc_write_unit.sv | 110 +++++++++++
 tb/tb_pc_write_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_write_unit.sv
// PC register with branch-condition evaluation, jump/branch/sequential arbitration and stall-deferred redirect replay.
// PC updates on the edge after pc_write_2=1; a redirect deferred by stall is replayed on the first non-stall cycle.
module pc_write_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_write,
  input  logic             branch,
  input  logic [1:0]       br_type,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             jump,
  input  logic             stall,
  input  logic [WIDTH-1:0] pc_seq,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic             pc_write_2,
  output logic             pend_valid,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t           state;
  logic [WIDTH-1:0] pend_target;
  logic             cond;
  logic             take;
  logic             new_redirect;
  logic [WIDTH-1:0] new_target;
  logic [WIDTH-1:0] next_pc;

  always_comb begin
    cond = 1'b0;
    unique case (br_type)
      2'b00: cond = alu_zero;
      2'b01: cond = !alu_zero;
      2'b10: cond = alu_zero | alu_neg;
      2'b11: cond = !alu_zero & !alu_neg;
    endcase
  end

  assign take         = branch & cond;
  assign new_redirect = jump | take;
  assign new_target   = jump ? jump_target : br_target;

  // A redirect present in the release cycle is newer than the latched one, so it wins.
  always_comb begin
    pc_write_2 = 1'b0;
    next_pc    = pc;
    if (rst_n && !stall) begin
      if (state == PEND) begin
        pc_write_2 = 1'b1;
        next_pc    = new_redirect ? new_target : pend_target;
      end else if (new_redirect) begin
        pc_write_2 = 1'b1;
        next_pc    = new_target;
      end else if (pc_write) begin
        pc_write_2 = 1'b1;
        next_pc    = pc_seq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      taken_cnt   <= '0;
      ntaken_cnt  <= '0;
    end else begin
      if (pc_write_2) pc <= next_pc;

      // A sequential request under stall is dropped; only redirects are latched.
      unique case (state)
        IDLE: begin
          if (stall && new_redirect) begin
            pend_target <= new_target;
            pend_valid  <= 1'b1;
            state       <= PEND;
          end
        end
        PEND: begin
          if (stall) begin
            if (new_redirect) pend_target <= new_target;
          end else begin
            pend_valid <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase

      // Outcome is counted when evaluated, even if the redirect itself is deferred.
      if (branch) begin
        if (cond) begin
          if (taken_cnt != {CNT_W{1'b1}}) taken_cnt <= taken_cnt + 1'b1;
        end else begin
          if (ntaken_cnt != {CNT_W{1'b1}}) ntaken_cnt <= ntaken_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_write_unit.sv
// Bench for pc_write_unit: reference model checked every cycle plus literal spot checks.
module tb_pc_write_unit;

  localparam int          WIDTH = 32;
  localparam int          CNT_W = 4;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic             clk = 1'b0;
  logic             rst_n, pc_write, branch, alu_zero, alu_neg, jump, stall;
  logic [1:0]       br_type;
  logic [WIDTH-1:0] pc_seq, br_target, jump_target, pc;
  logic             pc_write_2, pend_valid;
  logic [CNT_W-1:0] taken_cnt, ntaken_cnt;

  pc_write_unit #(.WIDTH(WIDTH), .RESET_PC(RPC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .branch(branch), .br_type(br_type),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .jump(jump), .stall(stall), .pc_seq(pc_seq),
    .br_target(br_target), .jump_target(jump_target), .pc(pc), .pc_write_2(pc_write_2),
    .pend_valid(pend_valid), .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ALU flags stand for a result value; conditions are plain comparisons on it.
  function automatic bit cond_of(input logic [1:0] t, input logic z, input logic n);
    int r;
    r = z ? 0 : (n ? -1 : 1);
    case (t)
      2'd0:    return r == 0;
      2'd1:    return r != 0;
      2'd2:    return r <= 0;
      default: return r > 0;
    endcase
  endfunction

  logic [31:0] m_pc;
  logic [31:0] m_q[$];  // deferred redirects, newest last
  int          m_tc, m_nc;
  localparam int SAT = (1 << CNT_W) - 1;

  function automatic bit m_redir();
    return jump || (branch && cond_of(br_type, alu_zero, alu_neg));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = RPC; m_q.delete(); m_tc = 0; m_nc = 0;
    end else begin
      if (stall) begin
        if (m_redir()) m_q.push_back(jump ? jump_target : br_target);
      end else begin
        if (m_redir())          m_pc = jump ? jump_target : br_target;
        else if (m_q.size() > 0) m_pc = m_q[$];
        else if (pc_write)      m_pc = pc_seq;
        m_q.delete();
      end
      if (branch) begin
        if (cond_of(br_type, alu_zero, alu_neg)) m_tc = (m_tc < SAT) ? m_tc + 1 : m_tc;
        else                                     m_nc = (m_nc < SAT) ? m_nc + 1 : m_nc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("pend_valid", 32'(pend_valid), 32'(m_q.size() > 0));
      chk("taken_cnt", 32'(taken_cnt), 32'(m_tc));
      chk("ntaken_cnt", 32'(ntaken_cnt), 32'(m_nc));
      chk("pc_write_2", 32'(pc_write_2),
          32'(rst_n && !stall && (m_redir() || m_q.size() > 0 || pc_write)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pc_write = 0; branch = 0; br_type = 0; alu_zero = 0; alu_neg = 0;
    jump = 0; stall = 0; pc_seq = 0; br_target = 0; jump_target = 0;
  endtask

  task automatic do_br(input logic [1:0] t, input logic z, input logic n, input logic [31:0] tgt);
    clr(); branch = 1; br_type = t; alu_zero = z; alu_neg = n; br_target = tgt;
    step();
  endtask

  task automatic stall_jump(input logic [31:0] tgt);
    clr(); stall = 1; jump = 1; jump_target = tgt;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    rst_n = 0;
    @(posedge clk); #1;
    chk_en = 1;
    chk("rst pc_write_2", 32'(pc_write_2), 32'd0);
    step();
    chk("rst pc", pc, 32'h0040_0000);
    chk("rst pend_valid", 32'(pend_valid), 32'd0);
    chk("rst taken", 32'(taken_cnt), 32'd0);
    chk("rst ntaken", 32'(ntaken_cnt), 32'd0);
    rst_n = 1;

    // BEQ taken, then BEQ not taken alongside a sequential write.
    clr(); branch = 1; br_type = 2'b00; alu_zero = 1; br_target = 32'h100;
    #1 chk("beq pc_write_2", 32'(pc_write_2), 32'd1);
    step();
    chk("beq pc", pc, 32'h100);
    chk("beq taken", 32'(taken_cnt), 32'd1);
    clr(); branch = 1; alu_zero = 0; br_target = 32'h100; pc_write = 1; pc_seq = 32'h104;
    step();
    chk("beq nt pc", pc, 32'h104);
    chk("beq nt ntaken", 32'(ntaken_cnt), 32'd1);

    // All branch types with {zero,neg} in {00,01,10}: 6 taken, 6 not taken.
    for (int t = 0; t < 4; t++)
      for (int zn = 0; zn < 3; zn++)
        do_br(2'(t), zn[1], zn[0], 32'h1000 + 32'(t * 16 + zn * 4));
    chk("sweep taken", 32'(taken_cnt), 32'd7);
    chk("sweep ntaken", 32'(ntaken_cnt), 32'd7);
    chk("sweep pc", pc, 32'h1030);

    // Stall replay.
    stall_jump(32'h2000);
    chk("stall pc hold", pc, 32'h1030);
    chk("stall pend", 32'(pend_valid), 32'd1);
    clr();
    #1 chk("release pc_write_2", 32'(pc_write_2), 32'd1);
    step();
    chk("replay pc", pc, 32'h2000);
    chk("replay pend", 32'(pend_valid), 32'd0);

    // Newest wins: taken branch under stall overwrites the pending jump.
    stall_jump(32'h2000);
    clr(); stall = 1; branch = 1; br_type = 2'b00; alu_zero = 1; br_target = 32'h3000;
    step();
    chk("stalled br counted", 32'(taken_cnt), 32'd8);
    clr(); step();
    chk("newest br pc", pc, 32'h3000);

    stall_jump(32'h2000);
    clr(); jump = 1; jump_target = 32'h4000; step();
    chk("release jump pc", pc, 32'h4000);

    stall_jump(32'h2000);
    clr(); pc_write = 1; pc_seq = 32'h5000; step();
    chk("release seq pc", pc, 32'h2000);

    // Sequential write under stall is dropped.
    clr(); stall = 1; pc_write = 1; pc_seq = 32'h6000; step();
    chk("drop pend", 32'(pend_valid), 32'd0);
    clr(); step();
    chk("drop pc", pc, 32'h2000);

    // Jump and taken branch together: jump wins, branch still counted.
    clr(); jump = 1; jump_target = 32'h7000; branch = 1; alu_zero = 1; br_target = 32'h7100;
    step();
    chk("jump+br pc", pc, 32'h7000);
    chk("jump+br taken", 32'(taken_cnt), 32'd9);

    // Saturation of both counters.
    for (int i = 0; i < 20; i++) do_br(2'b00, 1'b1, 1'b0, 32'h8000);
    for (int i = 0; i < 20; i++) do_br(2'b00, 1'b0, 1'b0, 32'h8800);
    chk("sat taken", 32'(taken_cnt), 32'd15);
    chk("sat ntaken", 32'(ntaken_cnt), 32'd15);

    // Reset while a redirect is pending discards it.
    stall_jump(32'h9000);
    chk("pre-rst pend", 32'(pend_valid), 32'd1);
    clr(); stall = 1; rst_n = 0; step();
    rst_n = 1; clr(); step();
    chk("post-rst pc", pc, 32'h0040_0000);
    chk("post-rst pend", 32'(pend_valid), 32'd0);
    chk("post-rst taken", 32'(taken_cnt), 32'd0);
    step();

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
